mod_inverse: RTL and testbench

Iterative modular inverse unit for the RLWE arithmetic datapath: it accepts a coefficient `a` and returns `a^(Q-2) mod Q`, which equals `a^-1 mod Q` because Q is prime. It is the inverse-direction companion of the combinational modular multiplier. It reuses one square/multiply reduction stage per cycle. Consumers are INTT scaling (n^-1) and key-generation paths that need coefficient inverses. Latency is fixed and independent of operand value (constant-time), with ready/valid handshakes on both sides.

---
 rtl/mod_inverse.sv | 107 ++++++++++
 tb/tb_mod_inverse.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mod_inverse.sv
// Constant-time modular inverse: out_inv = a^(Q-2) mod Q via left-to-right square/multiply,
// sharing one multiply-and-reduce stage between the SQ and MUL cycles.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// SQ    | r <= r*r mod Q
// MUL   | r <= E[k] ? r*base mod Q : r, step to next exponent bit
// DONE  | result presented, held until out_ready
module mod_inverse #(
  parameter int Q          = 12289,
  parameter int DATA_WIDTH = 14,
  parameter int EXP_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inv,
  output logic                  out_err
);

  localparam int KW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [DATA_WIDTH-1:0]   QD   = DATA_WIDTH'(Q);
  localparam logic [2*DATA_WIDTH-1:0] QW   = (2*DATA_WIDTH)'(Q);
  localparam logic [EXP_WIDTH-1:0]    E    = EXP_WIDTH'(Q - 2);
  localparam logic [KW-1:0]           KTOP = KW'(EXP_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SQ, MUL, DONE} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   r;
  logic [DATA_WIDTH-1:0]   base;
  logic [KW-1:0]           k;
  logic                    zero;

  logic [DATA_WIDTH-1:0]   base_in;
  logic [DATA_WIDTH-1:0]   mul_b;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]   red;
  logic [DATA_WIDTH-1:0]   r_mul;

  // 2^DATA_WIDTH < 2Q, so one conditional subtraction fully reduces the operand
  always_comb begin
    base_in = (in_a >= QD) ? (in_a - QD) : in_a;
    mul_b   = (state == SQ) ? r : base;
    prod    = {{DATA_WIDTH{1'b0}}, r} * {{DATA_WIDTH{1'b0}}, mul_b};
    red     = DATA_WIDTH'(prod % QW);
    r_mul   = E[k] ? red : r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_inv   <= '0;
      out_err   <= 1'b0;
      r         <= '0;
      base      <= '0;
      k         <= '0;
      zero      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            base     <= base_in;
            r        <= DATA_WIDTH'(1);
            k        <= KTOP;
            zero     <= (base_in == '0);
            in_ready <= 1'b0;
            state    <= SQ;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SQ: begin
          r     <= red;
          state <= MUL;
        end
        MUL: begin
          // multiply is always evaluated; the exponent bit only steers the mux
          r <= r_mul;
          if (k == '0) begin
            out_inv   <= r_mul;
            out_err   <= zero;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k     <= k - KW'(1);
            state <= SQ;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse.sv
// Directed and randomized checks of mod_inverse: known inverses, zero handling,
// fixed latency, backpressure, ignored mid-flight operands and reset abort.
module tb_mod_inverse;

  localparam int Q  = 12289;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_inv;
  logic          out_err;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  mod_inverse #(.Q(Q), .DATA_WIDTH(DW), .EXP_WIDTH(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inv   (out_inv),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("ready_valid_excl", {31'b0, in_ready & out_valid}, 32'd0);
  end

  // called at a negedge; returns one negedge after the accepting cycle
  task automatic start_op(input logic [DW-1:0] a, output int t_acc);
    int i = 0;
    while (!in_ready && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("ready_wait", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    t_acc    = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '0;
  endtask

  task automatic wait_result(input int t_acc, output logic [DW-1:0] inv, output logic err,
                             output int lat);
    int i = 0;
    while (!out_valid && i < 200) begin
      @(negedge clk);
      i++;
    end
    lat = out_valid ? (cyc - t_acc) : -1;
    inv = out_inv;
    err = out_err;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", {31'b0, out_valid}, 32'd0);
    check("ready_low_after_hs", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("ready_rise", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input logic [DW-1:0] a, input int exp_inv, input int exp_err);
    int t, lat;
    logic [DW-1:0] inv;
    logic err;
    start_op(a, t);
    wait_result(t, inv, err, lat);
    check($sformatf("inv(%0d)", a), 32'(inv), 32'(exp_inv));
    check($sformatf("err(%0d)", a), {31'b0, err}, 32'(exp_err));
    check($sformatf("lat(%0d)", a), 32'(lat), 32'd29);
    release_result();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, lat, seen;
    logic [DW-1:0] inv;
    logic err;
    int a;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_inv", 32'(out_inv), 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, in_ready}, 32'd1);

    run_vec(14'd2, 6145, 0);
    run_vec(14'd512, 12265, 0);
    run_vec(14'd3, 8193, 0);
    run_vec(14'd12288, 12288, 0);
    run_vec(14'd1, 1, 0);
    run_vec(14'd0, 0, 1);
    run_vec(14'd12289, 0, 1);
    run_vec(14'd12290, 1, 0);

    // backpressure: result must hold for 10 stalled cycles
    start_op(14'd3, t);
    wait_result(t, inv, err, lat);
    check("bp_lat", 32'(lat), 32'd29);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_inv", 32'(out_inv), 32'd8193);
      check("bp_err", {31'b0, out_err}, 32'd0);
      check("bp_ready", {31'b0, in_ready}, 32'd0);
    end
    release_result();

    // operand offered mid-computation must be ignored
    start_op(14'd512, t);
    repeat (5) @(negedge clk);
    in_valid = 1'b1;
    in_a     = 14'd2;
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '0;
    wait_result(t, inv, err, lat);
    check("ign_inv", 32'(inv), 32'd12265);
    check("ign_lat", 32'(lat), 32'd29);
    release_result();
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("ign_no_extra_result", 32'(seen), 32'd0);

    // reset at T+10 aborts the computation
    start_op(14'd3, t);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", {31'b0, out_valid}, 32'd0);
    check("abort_ready_rst_cycle", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("abort_ready_after", {31'b0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    run_vec(14'd2, 6145, 0);

    // random sweep: a * inv == 1 mod Q, constant latency
    for (int n = 0; n < 1000; n++) begin
      a = int'($urandom_range(1, Q - 1));
      start_op(DW'(a), t);
      wait_result(t, inv, err, lat);
      check($sformatf("rnd_prod(%0d)", a), 32'((longint'(a) * longint'(inv)) % Q), 32'd1);
      check($sformatf("rnd_err(%0d)", a), {31'b0, err}, 32'd0);
      check($sformatf("rnd_lat(%0d)", a), 32'(lat), 32'd29);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
